// File: rtl/cosim_tx_pkg.sv
// Shared constants, state encoding and helpers for the cosim UART transmit scheduler.
package cosim_tx_pkg;

  localparam logic [7:0] SLIP_END     = 8'hC0;
  localparam logic [7:0] SLIP_ESC     = 8'hDB;
  localparam logic [7:0] SLIP_ESC_END = 8'hDC;
  localparam logic [7:0] SLIP_ESC_ESC = 8'hDD;
  localparam logic [7:0] SLIP_ABORT   = 8'hDE;
  localparam logic [7:0] HDR_FLAG     = 8'h80;

  typedef enum logic [3:0] {
    IDLE,
    HEADER,
    PAYLOAD,
    ESC2,
    END,
    ABORT_ESC,
    ABORT_CODE,
    ABORT_END,
    DRAIN
  } tx_sched_state_e;

  // Index width that stays legal for a single-entry range.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin search: first set request at or above ptr_i, wrapping to the bottom.
module rr_arbiter
  import cosim_tx_pkg::*;
#(
  parameter int unsigned N = 4,
  localparam int unsigned IdxW = idx_width(N)
) (
  input  logic [N-1:0]    req_i,
  input  logic [IdxW-1:0] ptr_i,
  output logic            gnt_valid_o,
  output logic [IdxW-1:0] gnt_idx_o
);

  logic            hi_valid, lo_valid;
  logic [IdxW-1:0] hi_idx, lo_idx;

  // Descending scan so the lowest index in each half ends up selected.
  always_comb begin
    hi_valid = 1'b0;
    lo_valid = 1'b0;
    hi_idx   = '0;
    lo_idx   = '0;
    for (int k = int'(N) - 1; k >= 0; k--) begin
      if (req_i[k]) begin
        if (IdxW'(k) >= ptr_i) begin
          hi_valid = 1'b1;
          hi_idx   = IdxW'(k);
        end else begin
          lo_valid = 1'b1;
          lo_idx   = IdxW'(k);
        end
      end
    end
  end

  assign gnt_valid_o = hi_valid | lo_valid;
  assign gnt_idx_o   = hi_valid ? hi_idx : lo_idx;

endmodule

// File: rtl/cosim_tx_scheduler.sv
// Shares one UART byte stream between packet sources; frames each packet as header,
// SLIP-escaped payload and END, and aborts packets whose source stalls too long.
module cosim_tx_scheduler
  import cosim_tx_pkg::*;
#(
  parameter int unsigned REQ_COUNT = 16,
  parameter int unsigned TIMEOUT   = 50_000,
  localparam int unsigned IdxW = idx_width(REQ_COUNT)
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic [REQ_COUNT-1:0]      req_valid_i,
  input  logic [REQ_COUNT-1:0][7:0] req_data_i,
  input  logic [REQ_COUNT-1:0]      req_last_i,
  output logic [REQ_COUNT-1:0]      req_ready_o,
  output logic                      tx_valid_o,
  output logic [7:0]                tx_data_o,
  input  logic                      tx_ready_i,
  output logic                      busy_o,
  output logic [IdxW-1:0]           grant_idx_o,
  output logic                      abort_o
);

  localparam int unsigned TimerW = idx_width(TIMEOUT);

  tx_sched_state_e state_q, state_d;
  logic [IdxW-1:0] grant_q, grant_d, ptr_q, ptr_d, next_ptr;
  logic [TimerW-1:0] timer_q, timer_d;
  logic            tx_valid_q, tx_valid_d;
  logic [7:0]      tx_data_q, tx_data_d, pend_q, pend_d;
  logic            end_pend_q, end_pend_d, abort_q, abort_d;

  logic            gnt_valid;
  logic [IdxW-1:0] gnt_idx;
  logic            slot_free, cur_valid, cur_last, timeout_hit;
  logic [7:0]      cur_data;

  rr_arbiter #(
    .N (REQ_COUNT)
  ) u_arb (
    .req_i       (req_valid_i),
    .ptr_i       (ptr_q),
    .gnt_valid_o (gnt_valid),
    .gnt_idx_o   (gnt_idx)
  );

  assign slot_free   = !tx_valid_q || tx_ready_i;
  assign cur_valid   = req_valid_i[grant_q];
  assign cur_last    = req_last_i[grant_q];
  assign cur_data    = req_data_i[grant_q];
  assign timeout_hit = (timer_q == TimerW'(TIMEOUT - 1));
  assign next_ptr    = (grant_q == IdxW'(REQ_COUNT - 1)) ? '0 : grant_q + 1'b1;

  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    ptr_d       = ptr_q;
    timer_d     = timer_q;
    tx_valid_d  = tx_valid_q && !tx_ready_i;
    tx_data_d   = tx_data_q;
    pend_d      = pend_q;
    end_pend_d  = end_pend_q;
    abort_d     = 1'b0;
    req_ready_o = '0;

    unique case (state_q)
      IDLE: begin
        end_pend_d = 1'b0;
        if (gnt_valid) begin
          grant_d = gnt_idx;
          state_d = HEADER;
        end
      end
      HEADER: begin
        if (slot_free) begin
          tx_valid_d = 1'b1;
          tx_data_d  = HDR_FLAG | 8'(grant_q);
          state_d    = PAYLOAD;
        end
      end
      PAYLOAD: begin
        req_ready_o[grant_q] = slot_free;
        if (cur_valid && slot_free) begin
          timer_d    = '0;
          tx_valid_d = 1'b1;
          if (cur_data == SLIP_END || cur_data == SLIP_ESC) begin
            tx_data_d  = SLIP_ESC;
            pend_d     = (cur_data == SLIP_END) ? SLIP_ESC_END : SLIP_ESC_ESC;
            end_pend_d = cur_last;
            state_d    = ESC2;
          end else begin
            tx_data_d = cur_data;
            if (cur_last) state_d = END;
          end
        end else if (!cur_valid) begin
          // Only source-side stalls count; a busy UART never triggers an abort.
          if (timeout_hit) begin
            abort_d = 1'b1;
            timer_d = '0;
            state_d = ABORT_ESC;
          end else begin
            timer_d = timer_q + 1'b1;
          end
        end
      end
      ESC2: begin
        if (slot_free) begin
          tx_valid_d = 1'b1;
          tx_data_d  = pend_q;
          state_d    = end_pend_q ? END : PAYLOAD;
        end
      end
      END: begin
        if (slot_free) begin
          tx_valid_d = 1'b1;
          tx_data_d  = SLIP_END;
          ptr_d      = next_ptr;
          state_d    = IDLE;
        end
      end
      ABORT_ESC: begin
        if (slot_free) begin
          tx_valid_d = 1'b1;
          tx_data_d  = SLIP_ESC;
          state_d    = ABORT_CODE;
        end
      end
      ABORT_CODE: begin
        if (slot_free) begin
          tx_valid_d = 1'b1;
          tx_data_d  = SLIP_ABORT;
          state_d    = ABORT_END;
        end
      end
      ABORT_END: begin
        if (slot_free) begin
          tx_valid_d = 1'b1;
          tx_data_d  = SLIP_END;
          state_d    = DRAIN;
        end
      end
      DRAIN: begin
        // Swallow the rest of the aborted packet so the source can resynchronise.
        req_ready_o[grant_q] = 1'b1;
        if (cur_valid) begin
          timer_d = '0;
          if (cur_last) begin
            ptr_d   = next_ptr;
            state_d = IDLE;
          end
        end else if (timeout_hit) begin
          timer_d = '0;
          ptr_d   = next_ptr;
          state_d = IDLE;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      grant_q    <= '0;
      ptr_q      <= '0;
      timer_q    <= '0;
      tx_valid_q <= 1'b0;
      tx_data_q  <= 8'h00;
      pend_q     <= 8'h00;
      end_pend_q <= 1'b0;
      abort_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      ptr_q      <= ptr_d;
      timer_q    <= timer_d;
      tx_valid_q <= tx_valid_d;
      tx_data_q  <= tx_data_d;
      pend_q     <= pend_d;
      end_pend_q <= end_pend_d;
      abort_q    <= abort_d;
    end
  end

  assign tx_valid_o  = tx_valid_q;
  assign tx_data_o   = tx_data_q;
  assign busy_o      = (state_q != IDLE);
  assign grant_idx_o = grant_q;
  assign abort_o     = abort_q;

endmodule

// File: tb/tb_cosim_tx_scheduler.sv
// Directed framing/abort scenarios plus a randomized multi-source run against a packet-level model.
module tb_cosim_tx_scheduler;

  localparam int unsigned N  = 16;
  localparam int unsigned TO = 16;

  logic              clk = 1'b0;
  logic              rst_i = 1'b1;
  logic [N-1:0]      req_valid = '0;
  logic [N-1:0]      req_last = '0;
  logic [N-1:0]      req_ready;
  logic [N-1:0][7:0] req_data = '0;
  logic              tx_valid, tx_ready = 1'b1, busy, abort;
  logic [7:0]        tx_data;
  logic [3:0]        grant_idx;

  cosim_tx_scheduler #(
    .REQ_COUNT (N),
    .TIMEOUT   (TO)
  ) dut (
    .clk_i       (clk),
    .rst_i       (rst_i),
    .req_valid_i (req_valid),
    .req_data_i  (req_data),
    .req_last_i  (req_last),
    .req_ready_o (req_ready),
    .tx_valid_o  (tx_valid),
    .tx_data_o   (tx_data),
    .tx_ready_i  (tx_ready),
    .busy_o      (busy),
    .grant_idx_o (grant_idx),
    .abort_o     (abort)
  );

  always #10 clk = ~clk;

  int         n_chk = 0, n_fail = 0;
  logic [7:0] src_q [N][$];
  bit         src_l [N][$];
  logic [7:0] exp_q [N][$];
  logic [7:0] cap_q [$];
  logic [7:0] want  [$];
  bit         mid [N];
  int         gap_run [N];
  int         acc_cnt [N];
  bit         rand_mode, gen_on, sb_en, tgl;
  logic [N-1:0] active;
  int         tx_mode, cur_src, mp, abort_cnt, pkts_gen, pkts_seen;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic push(input int s, input logic [7:0] b, input bit last);
    src_q[s].push_back(b);
    src_l[s].push_back(last);
  endtask

  // Packet plus its expected framing (payload escaped, then END); the header is checked via rr order.
  task automatic gen_pkt(input int s);
    int len;
    logic [7:0] b;
    len = $urandom_range(6, 1);
    for (int i = 0; i < len; i++) begin
      if ($urandom_range(3) == 0) b = $urandom_range(1) ? 8'hC0 : 8'hDB;
      else b = 8'($urandom);
      push(s, b, i == len - 1);
      if (b == 8'hC0) begin
        exp_q[s].push_back(8'hDB); exp_q[s].push_back(8'hDC);
      end else if (b == 8'hDB) begin
        exp_q[s].push_back(8'hDB); exp_q[s].push_back(8'hDD);
      end else begin
        exp_q[s].push_back(b);
      end
    end
    exp_q[s].push_back(8'hC0);
    pkts_gen++;
  endtask

  task automatic sb_byte(input logic [7:0] b);
    int e, s;
    logic [7:0] x;
    e = -1;
    if (cur_src < 0) begin
      for (int i = 0; i < int'(N); i++) begin
        s = (mp + i) % N;
        if (e < 0 && exp_q[s].size() > 0) e = s;
      end
      if (e < 0) begin
        n_chk++; n_fail++;
        $display("FAIL sb_hdr: got unexpected frame byte %0h, required no frame", b);
      end else begin
        chk("sb_hdr", b, 8'h80 | 8'(e));
        chk("sb_grant", grant_idx, e);
        cur_src = e;
        mp = (e + 1) % N;
      end
    end else if (exp_q[cur_src].size() == 0) begin
      n_chk++; n_fail++;
      $display("FAIL sb_byte: got extra byte %0h, required none", b);
    end else begin
      x = exp_q[cur_src].pop_front();
      chk("sb_byte", b, x);
      if (x == 8'hC0) begin
        cur_src = -1;
        pkts_seen++;
      end
    end
  endtask

  // Drive on the falling edge, observe after settling; handshakes seen here land at the next rise.
  task automatic step();
    bit gap;
    logic [N-1:0] oh;
    @(negedge clk);
    for (int s = 0; s < int'(N); s++) begin
      gap = rand_mode && mid[s] && gap_run[s] < 8 && ($urandom_range(3) == 0);
      gap_run[s] = gap ? gap_run[s] + 1 : 0;
      if (src_q[s].size() > 0 && !gap) begin
        req_valid[s] = 1'b1; req_data[s] = src_q[s][0]; req_last[s] = src_l[s][0];
      end else begin
        req_valid[s] = 1'b0; req_data[s] = 8'h00; req_last[s] = 1'b0;
      end
    end
    tgl = !tgl;
    tx_ready = (tx_mode == 0) ? 1'b1 : (tx_mode == 1) ? tgl : ($urandom_range(9) < 7);
    #1;
    if (!rst_i) begin
      if (tx_valid && tx_ready) begin
        cap_q.push_back(tx_data);
        if (sb_en) sb_byte(tx_data);
      end
      if (abort) abort_cnt++;
      chk("ready_onehot", ($countones(req_ready) <= 1), 1);
      if (sb_en && req_ready != '0) begin
        oh = '0;
        if (cur_src >= 0) oh[cur_src] = 1'b1;
        chk("sb_ready_src", req_ready, oh);
      end
      for (int s = 0; s < int'(N); s++) begin
        if (req_valid[s] && req_ready[s]) begin
          acc_cnt[s]++;
          mid[s] = !src_l[s][0];
          void'(src_q[s].pop_front());
          void'(src_l[s].pop_front());
          if (rand_mode && gen_on && active[s] && src_q[s].size() == 0) gen_pkt(s);
        end
      end
    end
  endtask

  task automatic do_reset(input bit check);
    rst_i = 1'b1;
    for (int s = 0; s < int'(N); s++) begin
      src_q[s].delete(); src_l[s].delete(); exp_q[s].delete();
      mid[s] = 1'b0; gap_run[s] = 0; acc_cnt[s] = 0;
    end
    cap_q.delete();
    cur_src = -1; mp = 0; abort_cnt = 0;
    rand_mode = 1'b0; sb_en = 1'b0; gen_on = 1'b0; tx_mode = 0;
    step();
    step();
    if (check) begin
      chk("rst_tx_valid", tx_valid, 0);
      chk("rst_tx_data", tx_data, 8'h00);
      chk("rst_req_ready", req_ready, 0);
      chk("rst_grant_idx", grant_idx, 0);
      chk("rst_abort", abort, 0);
      chk("rst_busy", busy, 0);
    end
    rst_i = 1'b0;
  endtask

  function automatic bit all_empty();
    for (int s = 0; s < int'(N); s++) if (src_q[s].size() != 0) return 1'b0;
    return 1'b1;
  endfunction

  task automatic run_idle(input string name);
    bit done;
    done = 1'b0;
    for (int i = 0; i < 5000 && !done; i++) begin
      step();
      done = all_empty() && !busy && !tx_valid;
    end
    chk({name, "_idle"}, done, 1);
  endtask

  task automatic wait_acc(input int s, input int n);
    for (int i = 0; i < 100 && acc_cnt[s] < n; i++) step();
    chk("wait_accept", (acc_cnt[s] >= n), 1);
  endtask

  task automatic cmp_stream(input string name);
    chk({name, "_len"}, cap_q.size(), want.size());
    for (int i = 0; i < want.size() && i < cap_q.size(); i++)
      chk($sformatf("%s_b%0d", name, i), cap_q[i], want[i]);
  endtask

  initial begin
    int k;
    bit seen;
    pkts_gen = 0; pkts_seen = 0; tgl = 1'b0;
    do_reset(1'b1);

    // Basic frame, then pointer sits at 4 so source 5 beats source 2.
    push(3, 8'h11, 1'b0); push(3, 8'h22, 1'b1);
    run_idle("t1");
    chk("t1_grant_idx", grant_idx, 3);
    want = '{8'h83, 8'h11, 8'h22, 8'hC0};
    cmp_stream("t1");
    cap_q.delete();
    push(2, 8'h02, 1'b1); push(5, 8'h05, 1'b1);
    run_idle("t1_ptr");
    want = '{8'h85, 8'h05, 8'hC0, 8'h82, 8'h02, 8'hC0};
    cmp_stream("t1_ptr");

    // Escapes under a toggling UART ready.
    do_reset(1'b0);
    tx_mode = 1;
    push(0, 8'hC0, 1'b0); push(0, 8'hDB, 1'b0); push(0, 8'h05, 1'b1);
    run_idle("t2");
    want = '{8'h80, 8'hDB, 8'hDC, 8'hDB, 8'hDD, 8'h05, 8'hC0};
    cmp_stream("t2");

    // Round robin across three continuously requesting sources.
    do_reset(1'b0);
    for (int r = 0; r < 2; r++) begin
      push(2, 8'h02, 1'b1); push(5, 8'h05, 1'b1); push(15, 8'h0F, 1'b1);
    end
    run_idle("t3");
    want = '{8'h82, 8'h02, 8'hC0, 8'h85, 8'h05, 8'hC0, 8'h8F, 8'h0F, 8'hC0,
             8'h82, 8'h02, 8'hC0, 8'h85, 8'h05, 8'hC0, 8'h8F, 8'h0F, 8'hC0};
    cmp_stream("t3");

    // Stall after one byte: abort pulse visible right after the 16th stalled cycle.
    do_reset(1'b0);
    push(1, 8'h55, 1'b0);
    wait_acc(1, 1);
    k = 0; seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      step();
      k++;
      if (abort) seen = 1'b1;
    end
    chk("t4_abort_cycle", k, 17);
    push(1, 8'h66, 1'b0); push(1, 8'h77, 1'b1);
    run_idle("t4");
    chk("t4_abort_pulses", abort_cnt, 1);
    want = '{8'h81, 8'h55, 8'hDB, 8'hDE, 8'hC0};
    cmp_stream("t4");

    // Reset while the escape's second byte is pending.
    do_reset(1'b0);
    push(0, 8'hC0, 1'b0); push(0, 8'h11, 1'b1);
    wait_acc(0, 1);
    rst_i = 1'b1;
    for (int s = 0; s < int'(N); s++) begin
      src_q[s].delete(); src_l[s].delete(); mid[s] = 1'b0;
    end
    step();
    rst_i = 1'b0;
    step();
    chk("t5_tx_valid", tx_valid, 0);
    chk("t5_busy", busy, 0);
    chk("t5_req_ready", req_ready, 0);
    cap_q.delete();
    push(7, 8'hDB, 1'b1);
    run_idle("t5");
    want = '{8'h87, 8'hDB, 8'hDD, 8'hC0};
    cmp_stream("t5");

    // Last byte arrives in exactly the cycle the timeout would fire.
    do_reset(1'b0);
    push(4, 8'h44, 1'b0);
    wait_acc(4, 1);
    repeat (15) step();
    push(4, 8'h45, 1'b1);
    run_idle("t6");
    chk("t6_no_abort", abort_cnt, 0);
    want = '{8'h84, 8'h44, 8'h45, 8'hC0};
    cmp_stream("t6");

    // Randomized: every active source always has a packet pending, random UART backpressure.
    do_reset(1'b0);
    pkts_gen = 0; pkts_seen = 0;
    active = N'($urandom);
    if ($countones(active) < 2) active = active | 16'h8421;
    rand_mode = 1'b1; sb_en = 1'b1; gen_on = 1'b1; tx_mode = 2;
    for (int s = 0; s < int'(N); s++) if (active[s]) gen_pkt(s);
    repeat (3000) step();
    gen_on = 1'b0;
    run_idle("rand");
    k = 0;
    for (int s = 0; s < int'(N); s++) k += exp_q[s].size();
    chk("rand_leftover", k, 0);
    chk("rand_pkts", pkts_seen, pkts_gen);
    chk("rand_no_abort", abort_cnt, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
